// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Purpose  : Shared types and constants for the FP32 divider result stage.
// Revision : 1.0 - initial release
// ============================================================================
package fp32_pkg;

  // Bit positions inside an exception vector {NV, DZ, OF, UF, NX}
  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  typedef logic [4:0] exc_t;

  // Canonical quiet NaN: positive sign, zero payload
  localparam logic [31:0] QNAN_CANON = 32'h7FC00000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] y;
    exc_t        exc;
  } res_t;

  // True for any NaN encoding (all-ones exponent, non-zero fraction)
  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fp32_skid_buf
// Purpose  : Two-entry FIFO-ordered skid buffer for res_t words, with flush.
//            Head register drives the outputs; the skid register absorbs the
//            one word that can arrive while the head is stalled. in_ready is
//            registered so it never depends combinationally on out_ready.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_skid_buf
  import fp32_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  res_t in_data,
  output logic out_valid,
  input  logic out_ready,
  output res_t out_data
);

  state_e state_q, state_d;
  res_t   head_q, head_d;
  res_t   skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  logic accept;
  logic retire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid & in_ready_q;
  assign retire    = out_valid & out_ready;

  // Next-state and datapath steering for head/skid registers
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          head_d  = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (retire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including a word accepted this cycle
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != TWO);
  end

  // State, data and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_div_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp32_div_result_stage
// Purpose  : Registered output stage behind the combinational FP32 divider.
//            Buffers result+exceptions in a 2-entry skid buffer, accumulates
//            retired exception bits into sticky fflags (software writable)
//            and counts retired results.
// Options  : FP32_RES_CANON_NAN_EN - when defined, NaN results are replaced
//            by the canonical quiet NaN on accept.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_div_result_stage
  import fp32_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [4:0] FLAGS_RST = 5'b00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic [4:0]       in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [4:0]       out_exc,
  input  logic             flush,
  input  logic             fflags_we,
  input  logic [4:0]       fflags_wdata,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] retired_cnt
);

  res_t in_res;
  res_t out_res;
  logic retire;

  exc_t             fflags_q, fflags_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  // Shape the incoming word; only the value may be rewritten, never the flags
  always_comb begin
    in_res.exc = in_exc;
`ifdef FP32_RES_CANON_NAN_EN
    in_res.y   = is_nan(in_y) ? QNAN_CANON : in_y;
`else
    in_res.y   = in_y;
`endif
  end

  fp32_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_res)
  );

  assign out_y   = out_res.y;
  assign out_exc = out_res.exc;
  assign retire  = out_valid & out_ready;

  // Sticky flag merge and retire counting; a retire in a flush cycle still counts
  always_comb begin
    fflags_d      = (fflags_we ? fflags_wdata : fflags_q) | (retire ? out_res.exc : 5'b00000);
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_q      <= FLAGS_RST;
      retired_cnt_q <= '0;
    end else begin
      fflags_q      <= fflags_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign fflags      = fflags_q;
  assign retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_div_result_stage
// Purpose  : Directed self-checking bench for fp32_div_result_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_div_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic [4:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_exc;
  logic        flush;
  logic        fflags_we;
  logic [4:0]  fflags_wdata;
  logic [4:0]  fflags;
  logic [3:0]  retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] nan_exp;

  always #5 clk = ~clk;

  fp32_div_result_stage #(
    .CNT_W     (4),
    .FLAGS_RST (5'b00000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_exc       (in_exc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_exc      (out_exc),
    .flush        (flush),
    .fflags_we    (fflags_we),
    .fflags_wdata (fflags_wdata),
    .fflags       (fflags),
    .retired_cnt  (retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic [4:0] e);
    in_valid = v;
    in_y     = y;
    in_exc   = e;
  endtask

  initial begin
`ifdef FP32_RES_CANON_NAN_EN
    nan_exp = 32'h7FC00000;
`else
    nan_exp = 32'hFFC12345;
`endif
    rst = 1'b1; flush = 1'b0; fflags_we = 1'b0; fflags_wdata = 5'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 5'b11111);  // must be ignored under reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'b0);
    @(negedge clk);

    // Reset / idle state
    chk("rst_fflags", 32'(fflags), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_cnt", 32'(retired_cnt), 32'h0);
    chk("rst_out_y", out_y, 32'h0);

    // Single transfer
    drive(1'b1, 32'h3F800000, 5'b0); out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 5'b0);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_y", out_y, 32'h3F800000);
    @(negedge clk);
    chk("single_retired", 32'(out_valid), 32'h0);
    chk("single_cnt", 32'(retired_cnt), 32'h1);
    chk("single_fflags", 32'(fflags), 32'h0);

    // Backpressure with three back-to-back words
    out_ready = 1'b0;
    drive(1'b1, 32'h40000000, 5'b00001);
    @(negedge clk);
    chk("bp_ready_one", 32'(in_ready), 32'h1);
    drive(1'b1, 32'h7F800000, 5'b01000);
    @(negedge clk);
    chk("bp_ready_two", 32'(in_ready), 32'h0);
    chk("bp_head_y", out_y, 32'h40000000);
    drive(1'b1, 32'h00000001, 5'b00011);
    @(negedge clk);
    chk("bp_hold_ready", 32'(in_ready), 32'h0);
    chk("bp_hold_y", out_y, 32'h40000000);
    chk("bp_hold_exc", 32'(out_exc), 32'h01);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_y", out_y, 32'h7F800000);
    chk("bp_second_exc", 32'(out_exc), 32'h08);
    chk("bp_ready_back", 32'(in_ready), 32'h1);
    chk("bp_fflags1", 32'(fflags), 32'h01);
    chk("bp_cnt2", 32'(retired_cnt), 32'h2);
    @(negedge clk);
    drive(1'b0, 32'h0, 5'b0);
    chk("bp_third_y", out_y, 32'h00000001);
    chk("bp_third_exc", 32'(out_exc), 32'h03);
    chk("bp_fflags2", 32'(fflags), 32'h09);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_fflags_final", 32'(fflags), 32'h0B);
    chk("bp_cnt4", 32'(retired_cnt), 32'h4);

    // Software write coinciding with a retire
    out_ready = 1'b0;
    fflags_we = 1'b1; fflags_wdata = 5'b00001;
    drive(1'b1, 32'h3F000000, 5'b00100);
    @(negedge clk);
    drive(1'b0, 32'h0, 5'b0);
    chk("wr_fflags", 32'(fflags), 32'h01);
    fflags_wdata = 5'b10000; out_ready = 1'b1;
    @(negedge clk);
    fflags_we = 1'b0;
    chk("wr_retire_fflags", 32'(fflags), 32'h14);
    chk("wr_retire_cnt", 32'(retired_cnt), 32'h5);

    // Flush with two entries buffered and no retire
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 5'b00010);
    @(negedge clk);
    drive(1'b1, 32'h22222222, 5'b00010);
    @(negedge clk);
    chk("fl_two_ready", 32'(in_ready), 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'b0);
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_in_ready", 32'(in_ready), 32'h1);
    chk("fl_fflags", 32'(fflags), 32'h14);
    chk("fl_cnt", 32'(retired_cnt), 32'h5);

    // Flush with a retire and an accept in the same cycle
    drive(1'b1, 32'h33333333, 5'b00001);
    @(negedge clk);
    drive(1'b1, 32'h44444444, 5'b01000);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'b0);
    chk("flr_out_valid", 32'(out_valid), 32'h0);
    chk("flr_fflags", 32'(fflags), 32'h15);
    chk("flr_cnt", 32'(retired_cnt), 32'h6);
    @(negedge clk);
    chk("flr_discarded", 32'(out_valid), 32'h0);

    // NaN handling
    drive(1'b1, 32'hFFC12345, 5'b10000);
    @(negedge clk);
    drive(1'b0, 32'h0, 5'b0);
    chk("nan_y", out_y, nan_exp);
    chk("nan_exc", 32'(out_exc), 32'h10);
    out_ready = 1'b1;
    @(negedge clk);
    chk("nan_cnt", 32'(retired_cnt), 32'h7);

    // Streaming: 9 more retires take the 4-bit counter from 7 through wrap to 0
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h3F800000 + 32'(i), 5'b0);
      @(negedge clk);
      if (i > 0) chk("stream_y", out_y, 32'h3F800000 + 32'(i));
    end
    drive(1'b0, 32'h0, 5'b0);
    chk("stream_last_y", out_y, 32'h3F800008);
    chk("stream_cnt15", 32'(retired_cnt), 32'hF);
    @(negedge clk);
    chk("wrap_cnt", 32'(retired_cnt), 32'h0);
    chk("wrap_empty", 32'(out_valid), 32'h0);
    chk("wrap_fflags", 32'(fflags), 32'h15);

    // Reset overrides a concurrent software write
    fflags_we = 1'b1; fflags_wdata = 5'b11111; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fflags_we = 1'b0;
    chk("rst2_fflags", 32'(fflags), 32'h0);
    chk("rst2_cnt", 32'(retired_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
